mmio_gpio_responder: RTL

Memory-mapped GPIO target for the multicycle MIPS core. Sits on the same address/write-data/write-enable bus the datapath drives toward the memory system and answers accesses that fall inside a 16-byte I/O window. Latches software-written output bits onto the LEDs. Synchronizes and debounces the 8 board switches, exposing them as a readable register plus a sticky change flag and interrupt.

---
 rtl/mmio_gpio_responder_pkg.sv | 13 +
 rtl/mmio_gpio_responder_if.sv | 29 ++
 rtl/mmio_gpio_responder_debounce.sv | 54 +++++
 rtl/mmio_gpio_responder.sv | 81 ++++++++
 4 files changed

// File: rtl/mmio_gpio_responder_pkg.sv
// Shared constants for the memory-mapped GPIO responder: register offsets,
// STATUS bit positions and the default switch debounce length.
package gpio_bus_pkg;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  localparam int STATUS_CHG_BIT = 0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/mmio_gpio_responder_if.sv
// Datapath-side bus seen by the GPIO responder: address, store data and
// strobe driven by the core, plus read data and window hit returned to it.
interface mmio_gpio_responder_if #(
  parameter int DataWidth = 32
);

  logic [DataWidth-1:0] address_i;
  logic [DataWidth-1:0] write_data_i;
  logic                 mem_write_i;
  logic [DataWidth-1:0] read_data_o;
  logic                 hit_o;

  modport master (
    output address_i,
    output write_data_i,
    output mem_write_i,
    input  read_data_o,
    input  hit_o
  );

  modport slave (
    input  address_i,
    input  write_data_i,
    input  mem_write_i,
    output read_data_o,
    output hit_o
  );

endinterface

// File: rtl/mmio_gpio_responder_debounce.sv
// Two-flop synchronizer plus whole-vector debouncer for the 8 board switches.
// update_o is high in the cycle before debounced_o takes a new value.
module gpio_debounce
  import gpio_bus_pkg::*;
#(
  parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] gpio_i,
  output logic [7:0] debounced_o,
  output logic       update_o
);

  localparam int                 CntWidth = $clog2(DebounceCycles);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(DebounceCycles - 1);

  logic [7:0]          r_sync1;
  logic [7:0]          r_sync2;
  logic [7:0]          r_sample;
  logic [CntWidth-1:0] r_cnt;
  logic [7:0]          r_debounced;

  logic w_stable;
  logic w_settled;

  assign w_stable    = (r_sync2 == r_sample);
  assign w_settled   = (r_cnt == CntMax);
  assign update_o    = w_stable && w_settled && (r_debounced != r_sample);
  assign debounced_o = r_debounced;

  // Any bit change restarts the shared counter; the counter saturates once settled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sample    <= '0;
      r_cnt       <= '0;
      r_debounced <= '0;
    end else begin
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
      if (!w_stable) begin
        r_sample <= r_sync2;
        r_cnt    <= '0;
      end else if (update_o) begin
        r_debounced <= r_sample;
      end else if (r_cnt < CntMax) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_gpio_responder.sv
// Memory-mapped GPIO target on the multicycle MIPS data bus: LED output
// register, debounced switch input register and a sticky change flag/IRQ.
module mmio_gpio_responder
  import gpio_bus_pkg::*;
#(
  parameter int                   DataWidth      = 32,
  parameter logic [DataWidth-1:0] BaseAddr       = DataWidth'(32'h1001_0040),
  parameter int                   DebounceCycles = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  mmio_gpio_responder_if.slave         bus,
  input  logic [7:0]                   gpio_i,
  output logic [7:0]                   gpio_o,
  output logic                         irq_o
);

  logic                 w_hit;
  logic [1:0]           w_offset;
  logic                 w_write;
  logic                 w_clear;
  logic [7:0]           w_debounced;
  logic                 w_update;
  logic [DataWidth-1:0] w_rdata;

  logic [7:0] r_out;
  logic       r_flag;

  assign w_hit    = (bus.address_i[DataWidth-1:4] == BaseAddr[DataWidth-1:4]);
  assign w_offset = bus.address_i[3:2];
  assign w_write  = bus.mem_write_i && w_hit;
  assign w_clear  = w_write && (w_offset == OFF_STATUS)
                    && bus.write_data_i[STATUS_CHG_BIT];

  gpio_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .gpio_i     (gpio_i),
    .debounced_o(w_debounced),
    .update_o   (w_update)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out <= '0;
    end else if (w_write && (w_offset == OFF_OUT)) begin
      r_out <= bus.write_data_i[7:0];
    end
  end

  // A new debounced value outranks a same-cycle software clear so no change is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flag <= 1'b0;
    end else if (w_update) begin
      r_flag <= 1'b1;
    end else if (w_clear) begin
      r_flag <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_offset)
        OFF_OUT:    w_rdata[7:0]          = r_out;
        OFF_IN:     w_rdata[7:0]          = w_debounced;
        OFF_STATUS: w_rdata[STATUS_CHG_BIT] = r_flag;
        default:    w_rdata               = '0;
      endcase
    end
  end

  assign bus.hit_o       = w_hit;
  assign bus.read_data_o = w_rdata;
  assign gpio_o          = r_out;
  assign irq_o           = r_flag;

endmodule
